// File: rtl/uart_transmitter_frame_controller_pkg.sv
// Shared types and width helpers for the UART transmit frame controller.
//   state_t  : frame serialiser FSM states
//   width_of : counter width for a modulus, never less than 1 bit
package uart_tx_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOAD      = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_transmitter_frame_controller_sync_fifo.sv
// Synchronous frame queue with registered full/empty flags.
// Ports:
//   clk, reset       clock, async active-high reset
//   push, wr_data    enqueue request and entry (accepted when not full or popping)
//   pop              dequeue request (ignored when empty)
//   rd_data          head entry, read from the flop array at the registered pointer
//   full, empty      registered occupancy flags
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic             push_ok, pop_ok;

  // A push into a full queue is fine when the head leaves in the same cycle.
  assign push_ok  = push && (!full || pop);
  assign pop_ok   = pop && !empty;
  assign wr_ptr_n = wr_ptr + (AW+1)'(push_ok);
  assign rd_ptr_n = rd_ptr + (AW+1)'(pop_ok);
  assign rd_data  = mem[rd_ptr[AW-1:0]];

  // Storage: no reset needed, entries are only read once written.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  // Pointers with an extra wrap bit distinguish full from empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      empty  <= (wr_ptr_n == rd_ptr_n);
      full   <= (wr_ptr_n[AW] != rd_ptr_n[AW]) &&
                (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);
    end
  end

endmodule

// File: rtl/uart_transmitter_frame_controller.sv
// Queues ALU results and register read data as frames and serialises them
// byte by byte into the UART transmitter over a valid/busy handshake.
// Ports:
//   clk, reset                       reference clock, async active-high reset
//   ALU_result_valid, ALU_result     enqueue a RESULT_BYTES frame
//   read_data_valid, read_data       enqueue a 1-byte frame
//   transmitter_busy_synchronized    UART TX busy, already in the clk domain
//   transmitter_parallel_data        byte presented to the TX (held between strobes)
//   transmitter_parallel_data_valid  1-cycle load strobe to the TX
//   UART_receiver_controller_enable  high while idle with nothing queued
//   fifo_full                        frame queue full
//   request_dropped                  1-cycle pulse when a strobe was lost
module uart_transmitter_frame_controller
  import uart_tx_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned RESULT_BYTES = 2,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned MSB_FIRST    = 0,
  parameter int unsigned BUSY_TIMEOUT = 1024
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               ALU_result_valid,
  input  logic [RESULT_BYTES*DATA_WIDTH-1:0] ALU_result,
  input  logic                               read_data_valid,
  input  logic [DATA_WIDTH-1:0]              read_data,
  input  logic                               transmitter_busy_synchronized,
  output logic [DATA_WIDTH-1:0]              transmitter_parallel_data,
  output logic                               transmitter_parallel_data_valid,
  output logic                               UART_receiver_controller_enable,
  output logic                               fifo_full,
  output logic                               request_dropped
);

  localparam int unsigned PAYLOAD_W = RESULT_BYTES * DATA_WIDTH;
  localparam int unsigned LEN_W     = $clog2(RESULT_BYTES) + 1;
  localparam int unsigned TIMER_W   = width_of(BUSY_TIMEOUT);
  localparam int unsigned ENTRY_W   = PAYLOAD_W + LEN_W;

  state_t                state_q, state_d;
  logic [PAYLOAD_W-1:0]  payload_q, payload_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [LEN_W-1:0]      idx_q, idx_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  enable_q, enable_d;
  logic                  drop_q, drop_d;

  logic                  busy;
  logic                  pop, push;
  logic [ENTRY_W-1:0]    wr_entry;
  logic [ENTRY_W-1:0]    head;
  logic                  fifo_empty;
  logic [LEN_W-1:0]      sel_c;
  logic [DATA_WIDTH-1:0] byte_c;

  assign busy = transmitter_busy_synchronized;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (wr_entry),
    .pop     (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      payload_q <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      timer_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      enable_q  <= 1'b1;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      payload_q <= payload_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      enable_q  <= enable_d;
      drop_q    <= drop_d;
    end
  end

  // Next-state, enqueue/drop and byte selection.
  always_comb begin
    state_d   = state_q;
    payload_d = payload_q;
    len_d     = len_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    pop       = 1'b0;
    push      = 1'b0;
    wr_entry  = '0;
    drop_d    = 1'b0;
    enable_d  = 1'b0;
    byte_c    = '0;

    // MSB-first walks the payload from byte len-1 down to byte 0.
    if (MSB_FIRST != 0) sel_c = len_q - idx_q - LEN_W'(1);
    else                sel_c = idx_q;
    for (int unsigned b = 0; b < RESULT_BYTES; b++) begin
      if (sel_c == LEN_W'(b)) byte_c = payload_q[b*DATA_WIDTH +: DATA_WIDTH];
    end

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          payload_d = head[ENTRY_W-1:LEN_W];
          len_d     = head[LEN_W-1:0];
          idx_d     = '0;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        if (!busy) begin
          data_d  = byte_c;
          valid_d = 1'b1;
          timer_d = '0;
          state_d = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        // A TX that never acknowledges gets the same byte again.
        if (busy)                                       state_d = WAIT_DONE;
        else if (timer_q == TIMER_W'(BUSY_TIMEOUT - 1)) state_d = LOAD;
        else                                            timer_d = timer_q + TIMER_W'(1);
      end
      WAIT_DONE: begin
        if (!busy) begin
          if (idx_q == len_q - LEN_W'(1)) begin
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + LEN_W'(1);
            state_d = LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // ALU strobe wins a collision; a full queue accepts only when popping.
    if (ALU_result_valid)     wr_entry = {ALU_result, LEN_W'(RESULT_BYTES)};
    else if (read_data_valid) wr_entry = {PAYLOAD_W'(read_data), LEN_W'(1)};
    push   = (ALU_result_valid || read_data_valid) && (!fifo_full || pop);
    drop_d = (ALU_result_valid && read_data_valid) ||
             ((ALU_result_valid || read_data_valid) && fifo_full && !pop);

    enable_d = (state_d == IDLE) && fifo_empty && !push;
  end

  assign transmitter_parallel_data       = data_q;
  assign transmitter_parallel_data_valid = valid_q;
  assign UART_receiver_controller_enable = enable_q;
  assign request_dropped                 = drop_q;

endmodule
